// File: rtl/servo_pwm_vert.sv
// Vertical-axis servo driver: frame counter, saturating pulse-width position
// stepped once per frame by CNT_U/CNT_D, and a registered servo PWM output.
module servo_pwm_vert #(
  parameter int PERIOD   = 2000000,
  parameter int POS_MIN  = 100000,
  parameter int POS_MAX  = 200000,
  parameter int POS_INIT = 150000,
  parameter int STEP     = 1000,
  parameter int CW       = 21
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CNT_U,
  input  logic          CNT_D,
  output logic          PWM,
  output logic          PWM_limit,
  output logic          UP_OK,
  output logic          FRAME,
  output logic [CW-1:0] POS
);

  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(PERIOD - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] MIN_C    = CW'(POS_MIN);
  localparam logic [CW-1:0] MAX_C    = CW'(POS_MAX);
  localparam logic [CW-1:0] INIT_C   = CW'(POS_INIT);
  localparam logic [CW:0]   STEP_X   = (CW+1)'(STEP);
  localparam logic [CW:0]   MAX_X    = (CW+1)'(POS_MAX);
  localparam logic [CW:0]   DN_FLOOR = (CW+1)'(POS_MIN + STEP);

  localparam bit PARAMS_OK = (POS_MIN <= POS_INIT) && (POS_INIT <= POS_MAX) &&
                             (POS_MAX < PERIOD) && (STEP >= 1) && (POS_MIN >= 1) &&
                             (longint'(PERIOD) < (longint'(1) << CW));

  logic [CW-1:0] cnt;
  logic          frame_end;
  logic [CW:0]   pos_x;
  logic [CW:0]   up_sum;
  logic [CW:0]   dn_diff;
  logic [CW-1:0] pos_up;
  logic [CW-1:0] pos_dn;
  logic [CW-1:0] pos_next;

  assign frame_end = (cnt == CNT_LAST);

  // Extra headroom bit keeps the step arithmetic from wrapping before clamping.
  assign pos_x   = {1'b0, POS};
  assign up_sum  = pos_x + STEP_X;
  assign dn_diff = pos_x - STEP_X;
  assign pos_up  = (up_sum > MAX_X) ? MAX_C : up_sum[CW-1:0];
  assign pos_dn  = (pos_x < DN_FLOOR) ? MIN_C : dn_diff[CW-1:0];

  always_comb begin
    pos_next = POS;
    if (CNT_U && !CNT_D) begin
      pos_next = pos_up;
    end else if (CNT_D && !CNT_U) begin
      pos_next = pos_dn;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt   <= '0;
      POS   <= INIT_C;
      PWM   <= 1'b0;
      FRAME <= 1'b0;
    end else begin
      cnt   <= frame_end ? '0 : cnt + CNT_ONE;
      PWM   <= (cnt < POS);
      FRAME <= (cnt == CNT_PRE);
      // Position moves only on the frame boundary so a pulse never changes width.
      if (frame_end) begin
        POS <= pos_next;
      end
    end
  end

  assign PWM_limit = (POS > MIN_C);
  assign UP_OK     = (POS < MAX_C);

  always @(posedge CLK) begin
    assert (PARAMS_OK) else $error("servo_pwm_vert: illegal parameter set");
  end

endmodule

// File: tb/tb_servo_pwm_vert.sv
// Bench for servo_pwm_vert: directed frame-level scenarios plus randomized
// move enables and resets, checked against a frame-arithmetic reference model.
module tb_servo_pwm_vert;

  localparam int P     = 100;
  localparam int MIN   = 10;
  localparam int MAX   = 20;
  localparam int INIT  = 15;
  localparam int STEP  = 2;
  localparam int CW    = 7;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          cnt_u = 1'b0;
  logic          cnt_d = 1'b0;
  logic          pwm;
  logic          pwm_limit;
  logic          up_ok;
  logic          frame;
  logic [CW-1:0] pos;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: edges since reset release and the current frame width.
  int n      = 0;
  int m_pos  = INIT;
  int width  = 0;
  bit chk_en = 1'b0;
  logic [CW-1:0] exp_q[$];

  servo_pwm_vert #(
    .PERIOD(P), .POS_MIN(MIN), .POS_MAX(MAX), .POS_INIT(INIT), .STEP(STEP), .CW(CW)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .CNT_U(cnt_u), .CNT_D(cnt_d),
    .PWM(pwm), .PWM_limit(pwm_limit), .UP_OK(up_ok), .FRAME(frame), .POS(pos)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    return (v < MIN) ? MIN : ((v > MAX) ? MAX : v);
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n     = 0;
      m_pos = INIT;
      width = 0;
      exp_q.delete();
    end else begin
      n++;
      if (n % P == 0) begin
        if (cnt_u && !cnt_d)      m_pos = clamp(m_pos + STEP);
        else if (cnt_d && !cnt_u) m_pos = clamp(m_pos - STEP);
      end
      if (n % P == 1) exp_q.push_back(CW'(m_pos));
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    int ph;
    if (chk_en) begin
      ph = n % P;
      check("pwm", pwm, (ph >= 1 && ph <= m_pos));
      check("frame", frame, (ph == P - 1));
      check("pos", pos, m_pos);
      check("pwm_limit", pwm_limit, (m_pos > MIN));
      check("up_ok", up_ok, (m_pos < MAX));
      if (rst_n) begin
        if (pwm) width++;
        if (frame) begin
          if (exp_q.size() == 0) check("pulse_q_empty", 1, 0);
          else check("pulse_width", width, exp_q.pop_front());
          width = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_phase(input int p);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((n % P) != p && k < 3 * P);
    check("wait_phase", n % P, p);
  endtask

  task automatic pulse_inputs(input logic u, input logic d);
    cnt_u = u;
    cnt_d = d;
    @(negedge clk);
    cnt_u = 1'b0;
    cnt_d = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_pos", pos, INIT);
    check("reset_pwm", pwm, 0);
    check("reset_limit", pwm_limit, 1);
    check("reset_up_ok", up_ok, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // idle frames at the centre position
    repeat (3 * P) @(negedge clk);
    check("idle_pos", pos, INIT);

    // climb into the upper stop
    cnt_u = 1'b1;
    repeat (4 * P) @(negedge clk);
    cnt_u = 1'b0;
    check("up_sat_pos", pos, MAX);
    check("up_sat_ok", up_ok, 0);

    // descend into the lower stop
    reset_dut();
    cnt_d = 1'b1;
    repeat (4 * P) @(negedge clk);
    cnt_d = 1'b0;
    check("dn_sat_pos", pos, MIN);
    check("dn_sat_limit", pwm_limit, 0);

    // mid-frame enable is ignored; conflicting enables hold
    reset_dut();
    wait_phase(50);
    pulse_inputs(1'b0, 1'b1);
    wait_phase(99);
    pulse_inputs(1'b1, 1'b1);
    check("conflict_hold", pos, INIT);

    // single-cycle up enable on the boundary edge
    wait_phase(99);
    pulse_inputs(1'b1, 1'b0);
    check("single_up", pos, INIT + STEP);
    wait_phase(99);
    pulse_inputs(1'b1, 1'b0);
    check("pos_19", pos, INIT + 2 * STEP);

    // asynchronous reset in the middle of a pulse
    wait_phase(5);
    check("pwm_before_rst", pwm, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", pwm, 0);
    check("async_rst_pos", pos, INIT);
    check("async_rst_frame", frame, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * P) @(negedge clk);

    // randomized move enables with occasional resets
    for (int i = 0; i < 40 * P; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) begin
        {cnt_u, cnt_d} = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1499) == 0) begin
        reset_dut();
      end
    end
    cnt_u = 1'b0;
    cnt_d = 1'b0;
    repeat (2 * P) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
